// File: rtl/correlation_accumulator_if.sv
// Handshake bundle between the multiplier, the correlation accumulator and
// the downstream peak-decision logic.
interface correlation_accumulator_if #(
    parameter int SAMPLES = 128,
    parameter int OSF     = 8
);
    localparam int N  = SAMPLES * OSF;
    localparam int OW = $clog2(N + 1);
    localparam int CW = $clog2(N) + 2;

    logic [N-1:0]         prod_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [OW-1:0]        ones_out;
    logic signed [CW-1:0] corr_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;

    modport master (
        output prod_in, in_valid, out_ready,
        input  in_ready, ones_out, corr_out, out_valid, busy
    );

    modport slave (
        input  prod_in, in_valid, out_ready,
        output in_ready, ones_out, corr_out, out_valid, busy
    );
endinterface

// File: rtl/correlation_accumulator.sv
// Multi-cycle popcount of the XNOR product vector into a bipolar correlation.
// Optional peak tracker is enabled with the PEAK_TRACK_EN macro.
module correlation_accumulator #(
    parameter int SAMPLES = 128,
    parameter int OSF     = 8,
    parameter int CHUNK   = 64,
    localparam int N      = SAMPLES * OSF,
    localparam int K      = N / CHUNK,
    localparam int OW     = $clog2(N + 1),
    localparam int CW     = $clog2(N) + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    correlation_accumulator_if.slave   bus
`ifdef PEAK_TRACK_EN
    ,
    input  logic                       peak_clr,
    output logic signed [CW-1:0]       peak_val,
    output logic [15:0]                peak_idx
`endif
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic logic [OW-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [OW-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK; i++) c = c + OW'(v[i]);
        return c;
    endfunction

    // Bipolar mapping 2*ones - N, evaluated modulo 2^CW; the range -N..+N fits.
    function automatic logic signed [CW-1:0] to_corr(input logic [OW-1:0] ones);
        logic [CW-1:0] dbl;
        dbl = CW'({ones, 1'b0});
        return $signed(dbl - CW'(N));
    endfunction

    state_t               state, state_nxt;
    logic [N-1:0]         shadow;
    logic [OW-1:0]        acc;
    logic [IW-1:0]        idx;
    logic [OW-1:0]        ones_q;
    logic signed [CW-1:0] corr_q;
    logic [OW-1:0]        acc_sum;
    logic signed [CW-1:0] corr_new;
    logic                 last;

    assign acc_sum  = acc + popcount(shadow[idx*CHUNK +: CHUNK]);
    assign corr_new = to_corr(acc_sum);
    assign last     = (idx == IW'(K - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = ACCUM;
            ACCUM:   if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // State, shadow capture and chunked accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            acc    <= '0;
            idx    <= '0;
            ones_q <= '0;
            corr_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shadow <= bus.prod_in;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_sum;
                    idx <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        ones_q <= acc_sum;
                        corr_q <= corr_new;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.ones_out  = ones_q;
    assign bus.corr_out  = corr_q;

`ifdef PEAK_TRACK_EN
    logic [15:0] vcnt;
    logic [15:0] vid;

    // Peak tracker: strict compare keeps the earliest index on ties
    always_ff @(posedge clk) begin
        if (!rst_n || peak_clr) begin
            peak_val <= to_corr('0);
            peak_idx <= '0;
            vcnt     <= '0;
            vid      <= '0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                vid  <= vcnt;
                vcnt <= vcnt + 16'd1;
            end
            if (state == ACCUM && last && corr_new > peak_val) begin
                peak_val <= corr_new;
                peak_idx <= vid;
            end
        end
    end
`endif
endmodule

// File: tb/tb_correlation_accumulator.sv
// Directed bench for correlation_accumulator (defaults: N=1024, K=16).
// Define PEAK_TRACK_EN for both files to exercise the peak tracker.
module tb_correlation_accumulator;
    localparam int N = 1024;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cycles;
    int   busy_cnt;
    int   vcount;
    logic [N-1:0]  vec;
    logic [11:0]   corr_bits;

    correlation_accumulator_if #(.SAMPLES(128), .OSF(8)) bus ();

`ifdef PEAK_TRACK_EN
    logic              peak_clr;
    logic signed [11:0] peak_val;
    logic [15:0]       peak_idx;
    logic [11:0]       peak_bits;
    assign peak_bits = peak_val;

    correlation_accumulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .peak_clr (peak_clr),
        .peak_val (peak_val),
        .peak_idx (peak_idx)
    );
`else
    correlation_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    assign corr_bits = bus.corr_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a vector, wait (bounded) for acceptance, then scramble prod_in.
    task automatic accept(input logic [N-1:0] v);
        int w;
        w = 0;
        bus.prod_in  = v;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && w < 50) begin
            step();
            w++;
        end
        chk("accept_ready", {31'b0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.prod_in  = ~v;
    endtask

    task automatic wait_result(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!bus.out_valid && cyc < 64) begin
            if (bus.busy) bcnt++;
            step();
            cyc++;
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.prod_in   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
`ifdef PEAK_TRACK_EN
        peak_clr = 1'b0;
`endif
        step();
        step();
        rst_n = 1'b1;

        chk("rst_in_ready",  {31'b0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_busy",      {31'b0, bus.busy}, 32'd0);
        chk("rst_ones",      {21'b0, bus.ones_out}, 32'd0);
        chk("rst_corr",      {20'b0, corr_bits}, 32'd0);
`ifdef PEAK_TRACK_EN
        chk("rst_peak_val", {20'b0, peak_bits}, 32'hC00);
        chk("rst_peak_idx", {16'b0, peak_idx}, 32'd0);
`endif

        // all ones: latency and busy duration
        accept({N{1'b1}});
        wait_result(cycles, busy_cnt);
        chk("t1_latency", cycles, 32'd16);
        chk("t1_busy",    busy_cnt, 32'd16);
        chk("t1_ones",    {21'b0, bus.ones_out}, 32'd1024);
        chk("t1_corr",    {20'b0, corr_bits}, 32'h400);
        chk("t1_in_ready_done", {31'b0, bus.in_ready}, 32'd0);
        step();
        chk("t1_out_valid_clr", {31'b0, bus.out_valid}, 32'd0);
        chk("t1_in_ready_idle", {31'b0, bus.in_ready}, 32'd1);

        // all zeros
        accept('0);
        wait_result(cycles, busy_cnt);
        chk("t2_ones", {21'b0, bus.ones_out}, 32'd0);
        chk("t2_corr", {20'b0, corr_bits}, 32'hC00);
        step();

        // alternating bits, then a lone top bit
        accept({512{2'b10}});
        wait_result(cycles, busy_cnt);
        chk("t3a_ones", {21'b0, bus.ones_out}, 32'd512);
        chk("t3a_corr", {20'b0, corr_bits}, 32'd0);
        step();
        vec = '0;
        vec[1023] = 1'b1;
        accept(vec);
        wait_result(cycles, busy_cnt);
        chk("t3b_ones", {21'b0, bus.ones_out}, 32'd1);
        chk("t3b_corr", {20'b0, corr_bits}, 32'hC02);
        step();

        // backpressure: 300 ones -> corr -424 held while a new vector waits
        bus.out_ready = 1'b0;
        vec = '0;
        for (int i = 0; i < 300; i++) vec[i] = 1'b1;
        accept(vec);
        wait_result(cycles, busy_cnt);
        bus.prod_in  = {N{1'b1}};
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("t4_hold_ones",  {21'b0, bus.ones_out}, 32'd300);
            chk("t4_hold_corr",  {20'b0, corr_bits}, 32'hE58);
            chk("t4_hold_ready", {31'b0, bus.in_ready}, 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        chk("t4_idle_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("t4_idle_ready", {31'b0, bus.in_ready}, 32'd1);
        step();
        chk("t4_second_busy", {31'b0, bus.busy}, 32'd1);
        bus.in_valid = 1'b0;
        bus.prod_in  = '0;
        wait_result(cycles, busy_cnt);
        chk("t4_second_latency", cycles, 32'd16);
        chk("t4_second_ones", {21'b0, bus.ones_out}, 32'd1024);
        step();

        // reset at idx=7 discards the in-flight vector
        accept({N{1'b1}});
        for (int i = 0; i < 7; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("t5_in_ready",  {31'b0, bus.in_ready}, 32'd1);
        chk("t5_busy",      {31'b0, bus.busy}, 32'd0);
        chk("t5_ones",      {21'b0, bus.ones_out}, 32'd0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid) vcount++;
            step();
        end
        chk("t5_no_result", vcount, 32'd0);
        accept({256{4'b0001}});
        wait_result(cycles, busy_cnt);
        chk("t5_next_ones", {21'b0, bus.ones_out}, 32'd256);
        chk("t5_next_corr", {20'b0, corr_bits}, 32'hE00);
        step();

`ifdef PEAK_TRACK_EN
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        accept({512{2'b10}});
        wait_result(cycles, busy_cnt);
        step();
        accept({N{1'b1}});
        wait_result(cycles, busy_cnt);
        step();
        accept('0);
        wait_result(cycles, busy_cnt);
        step();
        accept({N{1'b1}});
        wait_result(cycles, busy_cnt);
        step();
        chk("t6_peak_val", {20'b0, peak_bits}, 32'h400);
        chk("t6_peak_idx", {16'b0, peak_idx}, 32'd1);
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        chk("t6_clr_val", {20'b0, peak_bits}, 32'hC00);
        chk("t6_clr_idx", {16'b0, peak_idx}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
